// File: rtl/tjrpu_wb_pkg.sv
// ---------------------------------------------------------------------------
// tjrpu_wb_pkg
// Shared definitions for the tjrpu Wishbone slave front end:
//   - CSR word offsets (byte offset >> 2) inside the CSR region
//   - CTRL / STATUS bit indices
//   - slave FSM state encoding
//   - default read data returned when a memory access times out
// ---------------------------------------------------------------------------
package tjrpu_wb_pkg;

    // CSR word offsets, compared against wbs_adr_i[14:2]
    localparam logic [12:0] CSR_CTRL     = 13'h000;
    localparam logic [12:0] CSR_STATUS   = 13'h001;
    localparam logic [12:0] CSR_IRQ_EN   = 13'h002;
    localparam logic [12:0] CSR_IRQ_PEND = 13'h003;
    localparam logic [12:0] CSR_SCRATCH  = 13'h004;

    // CTRL bits
    localparam int CTRL_RUN_BIT = 0;
    localparam int CTRL_RST_BIT = 1;

    // STATUS bits
    localparam int STATUS_TO_BIT = 0;

    localparam int IRQ_W = 3;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_ACK  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/tjrpu_wb_csr.sv
// ---------------------------------------------------------------------------
// tjrpu_wb_csr
// Local register bank of the Wishbone slave.
//   CTRL     (0x00) [0] run, [1] rst            RW, update when sel[0]
//   STATUS   (0x04) [0] to  sticky               W1C, update when sel[0]
//   IRQ_EN   (0x08) [2:0]                        RW, update when sel[0]
//   IRQ_PEND (0x0C) [2:0] set by evt             W1C, update when sel[0]
//   SCRATCH  (0x10) 32-bit                       RW, byte lanes via sel
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_en           one-cycle write strobe from the slave FSM
//   word_addr       CSR word offset
//   wdata, sel      write data and byte selects
//   evt             core event pulses (set IRQ_PEND)
//   to_set          timeout pulse (sets STATUS.to)
//   rdata           combinational read mux output (0 for unmapped offsets)
//   irq             IRQ_PEND & IRQ_EN
//   core_run        CTRL.run
//   core_rst        CTRL.rst
// ---------------------------------------------------------------------------
module tjrpu_wb_csr
    import tjrpu_wb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [12:0]       word_addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        sel,
    input  logic [IRQ_W-1:0]  evt,
    input  logic              to_set,
    output logic [31:0]       rdata,
    output logic [IRQ_W-1:0]  irq,
    output logic              core_run,
    output logic              core_rst
);

    logic             ctrl_run;
    logic             ctrl_rst;
    logic             status_to;
    logic [IRQ_W-1:0] irq_en;
    logic [IRQ_W-1:0] irq_pend;
    logic [31:0]      scratch;

    // Non-SCRATCH registers are single-lane and only listen to byte lane 0.
    logic             lane0_wr;
    logic             status_w1c;
    logic [IRQ_W-1:0] pend_w1c;

    assign lane0_wr = wr_en & sel[0];

    always_comb begin
        status_w1c = 1'b0;
        pend_w1c   = '0;
        if (lane0_wr && (word_addr == CSR_STATUS)) begin
            status_w1c = wdata[STATUS_TO_BIT];
        end
        if (lane0_wr && (word_addr == CSR_IRQ_PEND)) begin
            pend_w1c = wdata[IRQ_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_run  <= 1'b0;
            ctrl_rst  <= 1'b1;
            status_to <= 1'b0;
            irq_en    <= '0;
            irq_pend  <= '0;
            scratch   <= '0;
        end else begin
            if (lane0_wr && (word_addr == CSR_CTRL)) begin
                ctrl_run <= wdata[CTRL_RUN_BIT];
                ctrl_rst <= wdata[CTRL_RST_BIT];
            end
            if (lane0_wr && (word_addr == CSR_IRQ_EN)) begin
                irq_en <= wdata[IRQ_W-1:0];
            end
            if (wr_en && (word_addr == CSR_SCRATCH)) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel[b]) begin
                        scratch[8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end
            // Set terms are OR-ed after the clear so a same-cycle set wins.
            status_to <= to_set | (status_to & ~status_w1c);
            irq_pend  <= evt | (irq_pend & ~pend_w1c);
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (word_addr)
            CSR_CTRL:     rdata = {30'h0, ctrl_rst, ctrl_run};
            CSR_STATUS:   rdata = {31'h0, status_to};
            CSR_IRQ_EN:   rdata = {{(32-IRQ_W){1'b0}}, irq_en};
            CSR_IRQ_PEND: rdata = {{(32-IRQ_W){1'b0}}, irq_pend};
            CSR_SCRATCH:  rdata = scratch;
            default:      rdata = 32'h0;
        endcase
    end

    assign irq      = irq_pend & irq_en;
    assign core_run = ctrl_run;
    assign core_rst = ctrl_rst;

endmodule

// File: rtl/tjrpu_wb_slave.sv
// ---------------------------------------------------------------------------
// tjrpu_wb_slave
// Wishbone classic slave front end. Decodes the 64 KiB window at BASE_ADDR:
// adr[15]=0 is the local CSR bank, adr[15]=1 is forwarded to the core's
// internal memory bus. Forwarded accesses are bounded by TIMEOUT cycles.
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i      Wishbone cycle, strobe, write enable
//   wbs_sel_i, wbs_adr_i      byte selects, byte address
//   wbs_dat_i / wbs_dat_o     write data / read data (0 outside ack)
//   wbs_ack_o                 single-cycle acknowledge
//   mem_req_o ... mem_wdata_o internal memory request and its payload
//   mem_ready_i, mem_rdata_i  internal memory completion and read data
//   evt_i / irq_o             core events in / interrupts out
//   core_run_o, core_rst_o    core run enable and soft reset (CTRL flops)
//   dbg_state                 current FSM state, for observation only
//
// Internal memory handshake: mem_req_o is the valid. Once raised, mem_req_o
// and every mem_* payload signal hold steady until the target asserts
// mem_ready_i (access completes on that edge, mem_rdata_i sampled there),
// the timeout expires, or the master drops wbs_cyc_i. mem_ready_i is only
// looked at while mem_req_o is high.
// ---------------------------------------------------------------------------
module tjrpu_wb_slave
    import tjrpu_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          MEM_AW    = 13,
    parameter int          TIMEOUT   = 64,
    parameter logic [31:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [31:0]       mem_rdata_i,
    input  logic [IRQ_W-1:0]  evt_i,
    output logic [IRQ_W-1:0]  irq_o,
    output logic              core_run_o,
    output logic              core_rst_o,
    output wb_state_e         dbg_state
);

    localparam int              CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    wb_state_e   state;
    wb_state_e   state_nxt;
    logic [CW-1:0] to_cnt;
    logic [31:0] rdata_q;
    logic [31:0] csr_rdata;

    logic hit;
    logic csr_hit;
    logic mem_hit;
    logic mem_timeout;
    logic csr_wr;

    // Byte-offset bits never participate in decode.
    logic unused_adr_lsb;
    assign unused_adr_lsb = &{1'b0, wbs_adr_i[1:0]};

    assign hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:16] == BASE_ADDR[31:16]);
    assign csr_hit = hit & ~wbs_adr_i[15];
    assign mem_hit = hit &  wbs_adr_i[15];

    // Ready takes priority over timeout on the final counted cycle; an
    // abort (cyc dropped) takes priority over both.
    assign mem_timeout = (state == ST_MEM) & wbs_cyc_i & ~mem_ready_i & (to_cnt == CNT_LAST);
    assign csr_wr      = (state == ST_IDLE) & csr_hit & wbs_we_i;

    // ---------------- state register ----------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (csr_hit) begin
                    state_nxt = ST_ACK;
                end else if (mem_hit) begin
                    state_nxt = ST_MEM;
                end
            end
            ST_MEM: begin
                if (!wbs_cyc_i) begin
                    state_nxt = ST_IDLE;
                end else if (mem_ready_i || (to_cnt == CNT_LAST)) begin
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    always_comb begin
        wbs_ack_o = (state == ST_ACK);
        wbs_dat_o = (state == ST_ACK) ? rdata_q : 32'h0;
        dbg_state = state;
    end

    // ---------------- datapath: memory bus, timeout counter, read data ----------------
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= '0;
            mem_wdata_o <= '0;
            to_cnt      <= '0;
            rdata_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (csr_hit) begin
                        rdata_q <= wbs_we_i ? 32'h0 : csr_rdata;
                    end else if (mem_hit) begin
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= wbs_we_i;
                        mem_addr_o  <= wbs_adr_i[MEM_AW+1:2];
                        mem_be_o    <= wbs_sel_i;
                        mem_wdata_o <= wbs_dat_i;
                        to_cnt      <= '0;
                    end
                end
                ST_MEM: begin
                    if (!wbs_cyc_i) begin
                        mem_req_o <= 1'b0;
                    end else if (mem_ready_i) begin
                        mem_req_o <= 1'b0;
                        rdata_q   <= mem_we_o ? 32'h0 : mem_rdata_i;
                    end else if (to_cnt == CNT_LAST) begin
                        mem_req_o <= 1'b0;
                        rdata_q   <= mem_we_o ? 32'h0 : ERR_DATA;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: begin
                    rdata_q <= 32'h0;
                end
            endcase
        end
    end

    tjrpu_wb_csr u_csr (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .wr_en     (csr_wr),
        .word_addr (wbs_adr_i[14:2]),
        .wdata     (wbs_dat_i),
        .sel       (wbs_sel_i),
        .evt       (evt_i),
        .to_set    (mem_timeout),
        .rdata     (csr_rdata),
        .irq       (irq_o),
        .core_run  (core_run_o),
        .core_rst  (core_rst_o)
    );

endmodule
